sram_access_ctrl: RTL and testbench

- Sequences a multi-cycle, single-port external SRAM for the MEM stage of the 5-stage pipeline.
- Consumes the MEM_R_en/MEM_W_en produced by instruction decode and carried to MEM.
- Drives the SRAM strobes, holds each access for a fixed number of wait cycles, and returns registered read data.
- Drops `ready` to freeze the pipeline until the access completes.

---
 rtl/sram_access_ctrl_if.sv | 28 ++
 rtl/sram_access_ctrl.sv | 105 ++++++++++
 tb/tb_sram_access_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sram_access_ctrl_if.sv
// MEM-stage request/response and external SRAM pins for sram_access_ctrl.
// slave = the controller itself; master = pipeline plus SRAM side.
interface sram_access_ctrl_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 32
);
   logic              MEM_R_en;
   logic              MEM_W_en;
   logic [31:0]       address;
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] read_data;
   logic              ready;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;
   logic              sram_we_n;
   logic              sram_oe_n;

   modport slave (
      input  MEM_R_en, MEM_W_en, address, write_data, sram_rdata,
      output read_data, ready, sram_addr, sram_wdata, sram_we_n, sram_oe_n
   );

   modport master (
      output MEM_R_en, MEM_W_en, address, write_data, sram_rdata,
      input  read_data, ready, sram_addr, sram_wdata, sram_we_n, sram_oe_n
   );
endinterface

// File: rtl/sram_access_ctrl.sv
// Multi-cycle single-port SRAM sequencer for the MEM stage; freezes the
// pipeline through ready while strobes are held for WAIT_CYCLES cycles.
//
// state  | meaning
// IDLE   | no access; ready follows absence of request, request latched here
// ACCESS | strobes held, cnt counts 0..WAIT_CYCLES-1, ready low
// DONE   | access finished, ready high one cycle, requests ignored
module sram_access_ctrl #(
   parameter int ADDR_W      = 18,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 5
) (
   input logic                clk,
   input logic                rst,
   sram_access_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              op_wr_q, op_wr_d;
   logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
   logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
   logic [DATA_W-1:0] read_data_q, read_data_d;
   logic              we_n_q, we_n_d;
   logic              oe_n_q, oe_n_d;
   logic              req;

   assign req = bus.MEM_R_en | bus.MEM_W_en;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         op_wr_q      <= 1'b0;
         sram_addr_q  <= '0;
         sram_wdata_q <= '0;
         read_data_q  <= '0;
         we_n_q       <= 1'b1;
         oe_n_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         op_wr_q      <= op_wr_d;
         sram_addr_q  <= sram_addr_d;
         sram_wdata_q <= sram_wdata_d;
         read_data_q  <= read_data_d;
         we_n_q       <= we_n_d;
         oe_n_q       <= oe_n_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op_wr_d      = op_wr_q;
      sram_addr_d  = sram_addr_q;
      sram_wdata_d = sram_wdata_q;
      read_data_d  = read_data_q;
      we_n_d       = we_n_q;
      oe_n_d       = oe_n_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               // write wins when both enables are high
               state_d      = ACCESS;
               cnt_d        = '0;
               op_wr_d      = bus.MEM_W_en;
               sram_addr_d  = bus.address[ADDR_W+1:2];
               sram_wdata_d = bus.write_data;
               we_n_d       = ~bus.MEM_W_en;
               oe_n_d       = bus.MEM_W_en;
            end
         end
         ACCESS: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               we_n_d  = 1'b1;
               oe_n_d  = 1'b1;
               if (!op_wr_q) begin
                  read_data_d = bus.sram_rdata;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.ready      = (state_q == DONE) || ((state_q == IDLE) && !req);
      bus.read_data  = read_data_q;
      bus.sram_addr  = sram_addr_q;
      bus.sram_wdata = sram_wdata_q;
      bus.sram_we_n  = we_n_q;
      bus.sram_oe_n  = oe_n_q;
   end
endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with a behavioural SRAM model.
module tb_sram_access_ctrl;
   localparam int ADDR_W = 18;
   localparam int DATA_W = 32;
   localparam int WAIT_CYCLES = 5;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   sram_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   sram_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.sram_rdata = (!bus.sram_oe_n) ? mem[bus.sram_addr] : 32'h0;
   always @(posedge clk) begin
      if (!bus.sram_we_n) mem[bus.sram_addr] <= bus.sram_wdata;
   end

   typedef struct {
      bit          r_en;
      bit          w_en;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          pert;
      logic [31:0] alt_addr;
      logic [17:0] exp_sa;
      int          exp_we;
      int          exp_oe;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Call at ~1ns after a rising edge with the controller in IDLE.
   task automatic run_vec(input vec_t v, input int idx);
      int freeze = 0;
      int we_c = 0;
      int oe_c = 0;
      bit pins_ok = 1'b1;
      bit done = 1'b0;
      bus.MEM_R_en   = v.r_en;
      bus.MEM_W_en   = v.w_en;
      bus.address    = v.addr;
      bus.write_data = v.wdata;
      for (int cyc = 0; cyc < 40; cyc++) begin
         #1;
         if (v.pert != 0 && cyc == v.pert) begin
            bus.MEM_R_en   = 1'b0;
            bus.MEM_W_en   = 1'b0;
            bus.address    = v.alt_addr;
            bus.write_data = ~v.wdata;
            #1;
         end
         if (!bus.sram_we_n) begin
            we_c++;
            if (bus.sram_addr !== v.exp_sa || bus.sram_wdata !== v.wdata) pins_ok = 1'b0;
         end
         if (!bus.sram_oe_n) begin
            oe_c++;
            if (bus.sram_addr !== v.exp_sa) pins_ok = 1'b0;
         end
         if (bus.ready) begin
            done = 1'b1;
            break;
         end
         freeze++;
         @(posedge clk);
      end
      if (!done) begin
         errors++;
         checks++;
         $display("FAIL vec%0d timeout: ready never returned, expected within 40 cycles", idx);
      end
      chk($sformatf("vec%0d freeze_cycles", idx), 32'(freeze), 32'(WAIT_CYCLES + 1));
      chk($sformatf("vec%0d we_cycles", idx), 32'(we_c), 32'(v.exp_we));
      chk($sformatf("vec%0d oe_cycles", idx), 32'(oe_c), 32'(v.exp_oe));
      chk($sformatf("vec%0d sram_pins", idx), 32'(pins_ok), 32'd1);
      chk($sformatf("vec%0d read_data", idx), bus.read_data, v.exp_rd);
      if (v.w_en) chk($sformatf("vec%0d mem", idx), mem[v.exp_sa], v.wdata);
      bus.MEM_R_en = 1'b0;
      bus.MEM_W_en = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d idle_ready", idx), 32'(bus.ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{0, 1, 32'h0000_0410, 32'hDEAD_BEEF, 0, 32'h0, 18'h104, 5, 0, 32'h0};
      vecs[1] = '{1, 0, 32'h0000_0410, 32'h0,        0, 32'h0, 18'h104, 0, 5, 32'hDEAD_BEEF};
      vecs[2] = '{1, 1, 32'h0000_0820, 32'h1234_5678, 0, 32'h0, 18'h208, 5, 0, 32'hDEAD_BEEF};
      vecs[3] = '{1, 0, 32'hFFF0_0823, 32'h0,        0, 32'h0, 18'h208, 0, 5, 32'h1234_5678};
      vecs[4] = '{0, 1, 32'h0000_07FC, 32'hCAFE_F00D, 0, 32'h0, 18'h1FF, 5, 0, 32'h1234_5678};
      vecs[5] = '{1, 0, 32'h0000_07FC, 32'h0,        0, 32'h0, 18'h1FF, 0, 5, 32'hCAFE_F00D};
      vecs[6] = '{1, 0, 32'h0000_0410, 32'h0,        2, 32'h0000_0820, 18'h104, 0, 5, 32'hDEAD_BEEF};
      vecs[7] = '{0, 1, 32'h0000_0900, 32'h0BAD_F00D, 3, 32'h0000_0410, 18'h240, 5, 0, 32'hDEAD_BEEF};

      rst_n = 1'b0;
      bus.MEM_R_en = 1'b0;
      bus.MEM_W_en = 1'b0;
      bus.address = '0;
      bus.write_data = '0;
      #22;
      chk("rst we_n", 32'(bus.sram_we_n), 32'd1);
      chk("rst oe_n", 32'(bus.sram_oe_n), 32'd1);
      chk("rst read_data", bus.read_data, 32'h0);
      chk("rst sram_addr", 32'(bus.sram_addr), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("idle ready", 32'(bus.ready), 32'd1);
      end
      chk("idle we_n/oe_n", {30'h0, bus.sram_we_n, bus.sram_oe_n}, 32'h3);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      for (int i = 0; i < 10; i++) @(posedge clk);
      #1;
      chk("read_data held", bus.read_data, 32'hDEAD_BEEF);
      chk("held ready", 32'(bus.ready), 32'd1);

      // reset during the third ACCESS cycle of a store
      bus.MEM_W_en   = 1'b1;
      bus.address    = 32'h0000_0410;
      bus.write_data = 32'h5555_5555;
      repeat (3) @(posedge clk);
      #2;
      chk("mid-access we_n", 32'(bus.sram_we_n), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("async rst we_n", 32'(bus.sram_we_n), 32'd1);
      chk("async rst oe_n", 32'(bus.sram_oe_n), 32'd1);
      chk("async rst read_data", bus.read_data, 32'h0);
      bus.MEM_W_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post-rst ready", 32'(bus.ready), 32'd1);
      run_vec('{1, 0, 32'h0000_0820, 32'h0, 0, 32'h0, 18'h208, 0, 5, 32'h1234_5678}, 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
